// File: rtl/lut_loader_pkg.sv
// lut_loader_pkg: shared states, LUT select codes and CMD byte layout (WR_CSUM exists only with LUT_LOADER_CHECKSUM_EN)
package lut_loader_pkg;
  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR_HI,
    S_ADDR_LO,
    S_LEN_HI,
    S_LEN_LO,
    S_WR_DATA,
`ifdef LUT_LOADER_CHECKSUM_EN
    S_WR_CSUM,
`endif
    S_RD_ADDR,
    S_RD_WAIT,
    S_RD_SEND,
    S_DONE
  } state_e;
  localparam int NUM_LUTS = 4;
  localparam logic [1:0] LUT_BPM1_I = 2'd0;
  localparam logic [1:0] LUT_BPM1_Q = 2'd1;
  localparam logic [1:0] LUT_BPM2_I = 2'd2;
  localparam logic [1:0] LUT_BPM2_Q = 2'd3;
  localparam int CMD_RD_BIT = 7;
  localparam int CMD_SEL_LSB = 0;
  localparam logic [7:0] CMD_RSVD_MASK = 8'h7C;
  localparam int LEN_W = 15;
  function automatic logic rx_state(state_e s);
    return !(s inside {S_RD_ADDR, S_RD_WAIT, S_RD_SEND, S_DONE});
  endfunction
endpackage

// File: rtl/lut_loader_rd_pipe.sv
// lut_loader_rd_pipe: delays a read request by RD_LAT cycles, then captures the selected LUT's doutb
module lut_loader_rd_pipe
  import lut_loader_pkg::*;
#(
  parameter int DATA_W = 7,
  parameter int RD_LAT = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             req_i,
  input  logic [1:0]                       sel_i,
  input  logic [NUM_LUTS-1:0][DATA_W-1:0]  dout_i,
  output logic                             cap_o,
  output logic [DATA_W-1:0]                data_o
);
  logic [RD_LAT-1:0] sr_q;
  logic [DATA_W-1:0] data_q;
  assign cap_o  = sr_q[RD_LAT-1];
  assign data_o = data_q;
  // request delay line; the word is latched when the request reaches the last stage
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q   <= '0;
      data_q <= '0;
    end else begin
      sr_q <= RD_LAT'({sr_q, req_i});
      if (cap_o) data_q <= dout_i[sel_i];
    end
  end
endmodule

// File: rtl/lut_loader.sv
// lut_loader: byte-stream writer/readback engine for the four feedback LUTs; LUT_LOADER_CHECKSUM_EN adds a write-frame checksum trailer
module lut_loader
  import lut_loader_pkg::*;
#(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 7,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [DATA_W-1:0] bpm_lut_dinb,
  output logic [ADDR_W-1:0] bpm_lut_addrb,
  output logic              bpm1_i_lut_web,
  output logic              bpm1_q_lut_web,
  output logic              bpm2_i_lut_web,
  output logic              bpm2_q_lut_web,
  input  logic [DATA_W-1:0] bpm1_i_lut_doutb,
  input  logic [DATA_W-1:0] bpm1_q_lut_doutb,
  input  logic [DATA_W-1:0] bpm2_i_lut_doutb,
  input  logic [DATA_W-1:0] bpm2_q_lut_doutb,
  input  logic              clr_err,
  output logic              busy,
  output logic              done,
  output logic              proto_err
);
`ifdef LUT_LOADER_CHECKSUM_EN
  localparam state_e WR_END = S_WR_CSUM;
  logic [7:0] csum_q;
`else
  localparam state_e WR_END = S_DONE;
`endif
  state_e              state_q, state_d;
  logic                rd_q;
  logic [1:0]          sel_q;
  logic [ADDR_W-1:0]   addr_q, addrb_q;
  logic [LEN_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   dinb_q, rd_word;
  logic [NUM_LUTS-1:0] web_q;
  logic                rx_ready_q, tx_valid_q, busy_q, done_q, err_q;
  logic                acc, cap, last, bad_cmd, err_set;
  assign acc     = rx_valid & rx_ready_q;
  assign last    = cnt_q == '0;
  assign bad_cmd = (rx_data & CMD_RSVD_MASK) != 8'h00;
`ifdef LUT_LOADER_CHECKSUM_EN
  assign err_set = acc & ((state_q == S_IDLE & bad_cmd) | (state_q == S_WR_CSUM & rx_data != csum_q));
`else
  assign err_set = acc & state_q == S_IDLE & bad_cmd;
`endif
  assign rx_ready       = rx_ready_q;
  assign tx_valid       = tx_valid_q;
  assign tx_data        = {{(8-DATA_W){1'b0}}, rd_word};
  assign bpm_lut_dinb   = dinb_q;
  assign bpm_lut_addrb  = addrb_q;
  assign bpm1_i_lut_web = web_q[LUT_BPM1_I];
  assign bpm1_q_lut_web = web_q[LUT_BPM1_Q];
  assign bpm2_i_lut_web = web_q[LUT_BPM2_I];
  assign bpm2_q_lut_web = web_q[LUT_BPM2_Q];
  assign busy           = busy_q;
  assign done           = done_q;
  assign proto_err      = err_q;

  lut_loader_rd_pipe #(.DATA_W(DATA_W), .RD_LAT(RD_LAT)) u_rd_pipe (
    .clk    (clk),
    .rst    (rst),
    .req_i  (state_q == S_RD_ADDR),
    .sel_i  (sel_q),
    .dout_i ({bpm2_q_lut_doutb, bpm2_i_lut_doutb, bpm1_q_lut_doutb, bpm1_i_lut_doutb}),
    .cap_o  (cap),
    .data_o (rd_word)
  );

  // frame sequencing: header bytes, then either the write data stream or the read/send loop
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (acc && !bad_cmd) state_d = S_ADDR_HI;
      S_ADDR_HI: if (acc) state_d = S_ADDR_LO;
      S_ADDR_LO: if (acc) state_d = S_LEN_HI;
      S_LEN_HI:  if (acc) state_d = S_LEN_LO;
      S_LEN_LO:  if (acc) state_d = rd_q ? S_RD_ADDR : S_WR_DATA;
      S_WR_DATA: if (acc && last) state_d = WR_END;
`ifdef LUT_LOADER_CHECKSUM_EN
      S_WR_CSUM: if (acc) state_d = S_DONE;
`endif
      S_RD_ADDR: state_d = S_RD_WAIT;
      S_RD_WAIT: if (cap) state_d = S_RD_SEND;
      S_RD_SEND: if (tx_ready) state_d = last ? S_DONE : S_RD_ADDR;
      default:   state_d = S_IDLE;
    endcase
  end

  // state, registered handshake/status outputs, header capture and LUT port-B drive
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rd_q       <= 1'b0;
      sel_q      <= '0;
      addr_q     <= '0;
      addrb_q    <= '0;
      cnt_q      <= '0;
      dinb_q     <= '0;
      web_q      <= '0;
      rx_ready_q <= 1'b0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef LUT_LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      rx_ready_q <= rx_state(state_d);
      tx_valid_q <= state_d == S_RD_SEND;
      busy_q     <= state_d != S_IDLE;
      done_q     <= state_d == S_DONE;
      err_q      <= err_set | (err_q & ~clr_err);
      web_q      <= '0;
`ifdef LUT_LOADER_CHECKSUM_EN
      if (acc) csum_q <= state_q == S_IDLE ? rx_data : csum_q + rx_data;
`endif
      if (acc) begin
        case (state_q)
          S_IDLE: begin
            rd_q  <= rx_data[CMD_RD_BIT];
            sel_q <= rx_data[CMD_SEL_LSB +: 2];
          end
          S_ADDR_HI: addr_q[ADDR_W-1:8] <= rx_data[ADDR_W-9:0];
          S_ADDR_LO: addr_q[7:0] <= rx_data;
          S_LEN_HI:  cnt_q[LEN_W-1:8] <= rx_data[LEN_W-9:0];
          S_LEN_LO:  cnt_q[7:0] <= rx_data;
          S_WR_DATA: begin
            addrb_q <= addr_q;
            dinb_q  <= rx_data[DATA_W-1:0];
            web_q   <= NUM_LUTS'(1) << sel_q;
            addr_q  <= addr_q + ADDR_W'(1);
            cnt_q   <= cnt_q - LEN_W'(1);
          end
          default: ;
        endcase
      end
      if (state_q == S_RD_SEND && tx_ready) begin
        addr_q <= addr_q + ADDR_W'(1);
        cnt_q  <= cnt_q - LEN_W'(1);
      end
      if (state_d == S_RD_ADDR) addrb_q <= state_q == S_RD_SEND ? addr_q + ADDR_W'(1) : addr_q;
    end
  end
endmodule

// File: tb/tb_lut_loader.sv
// tb_lut_loader: directed frames against lut_loader with LUT models, write monitor and readback checks
module tb_lut_loader;
  logic       clk = 0, rst, rx_valid, tx_ready, clr_err;
  logic [7:0] rx_data, tx_data;
  logic       rx_ready, tx_valid, busy, done, proto_err;
  logic [6:0] dinb, d1i, d1q, d2i, d2q;
  logic [14:0] addrb;
  logic       w1i, w1q, w2i, w2q;
  int total = 0, bad = 0, multi = 0, done_cnt = 0;
  int wl[$], wa[$], wd[$], got[$];
  logic [7:0] dat[$];
  int b, d0, n, unstable;
  logic tog, pv, pr;
  logic [7:0] pd;
`ifdef LUT_LOADER_CHECKSUM_EN
  logic [7:0] csum_off = 0;
`endif

  lut_loader dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .bpm_lut_dinb(dinb), .bpm_lut_addrb(addrb),
    .bpm1_i_lut_web(w1i), .bpm1_q_lut_web(w1q), .bpm2_i_lut_web(w2i), .bpm2_q_lut_web(w2q),
    .bpm1_i_lut_doutb(d1i), .bpm1_q_lut_doutb(d1q), .bpm2_i_lut_doutb(d2i), .bpm2_q_lut_doutb(d2q),
    .clr_err(clr_err), .busy(busy), .done(done), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  // one-cycle LUT read models; each LUT has a distinct pattern so a wrong mux select shows up
  always @(posedge clk) begin
    d1i <= addrb[6:0] ^ 7'h11;
    d1q <= addrb[6:0];
    d2i <= addrb[6:0] ^ 7'h22;
    d2q <= addrb[6:0] ^ 7'h44;
  end

  // log every write strobe and done pulse
  always @(negedge clk) begin
    if (w1i | w1q | w2i | w2q) begin
      wl.push_back(w1q ? 1 : w2i ? 2 : w2q ? 3 : 0);
      wa.push_back(int'(addrb));
      wd.push_back(int'(dinb));
      if ($countones({w1i, w1q, w2i, w2q}) > 1) multi++;
    end
    if (done) done_cnt++;
  end

  task automatic chk(input string tag, input int got_v, input int exp_v);
    total++;
    if (got_v !== exp_v) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got_v, exp_v);
    end
  endtask

  task automatic chk_wr(input string tag, input int i, input int lut, input int a, input int d);
    chk({tag, "_lut"}, i < wl.size() ? wl[i] : -1, lut);
    chk({tag, "_addr"}, i < wa.size() ? wa[i] : -1, a);
    chk({tag, "_data"}, i < wd.size() ? wd[i] : -1, d);
  endtask

  task automatic send(input logic [7:0] v);
    int k = 0;
    rx_data = v;
    rx_valid = 1;
    while (!rx_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!rx_ready) chk("rx_timeout", 0, 1);
    @(negedge clk);
    rx_valid = 0;
  endtask

  task automatic wr_frame(input logic [7:0] cmd, input logic [7:0] ah, input logic [7:0] al);
    logic [15:0] len;
`ifdef LUT_LOADER_CHECKSUM_EN
    logic [7:0] s;
`endif
    len = 16'(dat.size() - 1);
    send(cmd); send(ah); send(al); send(len[15:8]); send(len[7:0]);
    foreach (dat[i]) send(dat[i]);
`ifdef LUT_LOADER_CHECKSUM_EN
    s = cmd + ah + al + len[15:8] + len[7:0];
    foreach (dat[i]) s += dat[i];
    send(s + csum_off);
`endif
  endtask

  task automatic wait_idle;
    int k = 0;
    while (busy && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (busy) chk("idle_timeout", 1, 0);
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst = 1; rx_valid = 0; rx_data = 0; tx_ready = 0; clr_err = 0;
    repeat (3) @(negedge clk);
    chk("rst_rx_ready", rx_ready, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_web", {w1i, w1q, w2i, w2q}, 0);
    chk("rst_addrb", addrb, 0);
    chk("rst_dinb", dinb, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", proto_err, 0);
    rst = 0;
    repeat (2) @(negedge clk);

    b = wl.size(); d0 = done_cnt;
    dat = '{8'h11, 8'h22, 8'h33};
    wr_frame(8'h03, 8'h00, 8'h10);
    wait_idle();
    chk("t1_nwr", wl.size() - b, 3);
    chk_wr("t1_w0", b, 3, 'h10, 'h11);
    chk_wr("t1_w1", b + 1, 3, 'h11, 'h22);
    chk_wr("t1_w2", b + 2, 3, 'h12, 'h33);
    chk("t1_done", done_cnt - d0, 1);

    b = wl.size();
    dat = '{8'h05, 8'hFA};
    wr_frame(8'h00, 8'hFF, 8'hFF);
    wait_idle();
    chk("t2_nwr", wl.size() - b, 2);
    chk_wr("t2_w0", b, 0, 'h7FFF, 'h05);
    chk_wr("t2_w1", b + 1, 0, 'h0000, 'h7A);

    b = wl.size(); d0 = done_cnt;
    send(8'h81); send(8'h01); send(8'h00); send(8'h00); send(8'h03);
    got.delete();
    unstable = 0; n = 0; tog = 0; pv = 0; pr = 0; pd = 0;
    while (got.size() < 4 && n < 200) begin
      if (tx_valid && pv && !pr && tx_data != pd) unstable++;
      tog = ~tog;
      tx_ready = tog;
      if (tx_valid && tx_ready) got.push_back(int'(tx_data));
      pv = tx_valid; pr = tx_ready; pd = tx_data;
      @(negedge clk);
      n++;
    end
    tx_ready = 0;
    wait_idle();
    chk("t3_nrd", got.size(), 4);
    foreach (got[i]) chk($sformatf("t3_rd%0d", i), got[i], i);
    chk("t3_stable", unstable, 0);
    chk("t3_no_web", wl.size() - b, 0);
    chk("t3_done", done_cnt - d0, 1);

    send(8'h04);
    chk("t4_err", proto_err, 1);
    chk("t4_busy", busy, 0);
    clr_err = 1;
    @(negedge clk);
    clr_err = 0;
    chk("t4_clr", proto_err, 0);
    clr_err = 1;
    send(8'h7C);
    clr_err = 0;
    chk("t4_err_wins", proto_err, 1);
    clr_err = 1;
    @(negedge clk);
    clr_err = 0;
    b = wl.size(); d0 = done_cnt;
    dat = '{8'h55};
    wr_frame(8'h01, 8'h00, 8'h20);
    wait_idle();
    chk_wr("t4_w0", b, 1, 'h20, 'h55);
    chk("t4_done", done_cnt - d0, 1);
    chk("t4_err_clear", proto_err, 0);

    b = wl.size(); d0 = done_cnt;
    send(8'h02); send(8'h00); send(8'h40); send(8'h00); send(8'h03); send(8'h0A);
    rst = 1;
    @(negedge clk);
    chk("t5_busy", busy, 0);
    chk("t5_rx_ready", rx_ready, 0);
    rst = 0;
    repeat (3) @(negedge clk);
    chk("t5_nwr", wl.size() - b, 1);
    chk_wr("t5_w0", b, 2, 'h40, 'h0A);
    chk("t5_no_done", done_cnt - d0, 0);
    dat = '{8'h0C};
    wr_frame(8'h02, 8'h00, 8'h41);
    wait_idle();
    chk("t5_nwr2", wl.size() - b, 2);
    chk_wr("t5_w1", b + 1, 2, 'h41, 'h0C);

`ifdef LUT_LOADER_CHECKSUM_EN
    b = wl.size(); d0 = done_cnt;
    csum_off = 0;
    dat = '{8'h01, 8'h02};
    wr_frame(8'h00, 8'h02, 8'h00);
    wait_idle();
    chk("t6_ok_err", proto_err, 0);
    chk("t6_ok_nwr", wl.size() - b, 2);
    csum_off = 1;
    dat = '{8'h03, 8'h04};
    wr_frame(8'h00, 8'h02, 8'h10);
    wait_idle();
    chk("t6_bad_err", proto_err, 1);
    chk("t6_bad_nwr", wl.size() - b, 4);
    chk_wr("t6_w3", b + 3, 0, 'h211, 'h04);
    chk("t6_done", done_cnt - d0, 2);
`endif

    chk("web_onehot", multi, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lut_loader.md
Name: lut_loader

Overview:
- Host-side writer and readback engine for the four 7-bit gain/inverse-charge LUTs (bpm1_i, bpm1_q, bpm2_i, bpm2_q) on the feedback path.
- Consumes a byte command stream from the slow-domain host interface and drives the shared LUT port B: bpm_lut_dinb, bpm_lut_addrb and the four per-LUT web strobes.
- Streams LUT contents back on a byte transmit stream for verification.
- Instantiated in the slow_clk domain; its clk port is tied to slow_clk.

Parameters:
- ADDR_W, 15, LUT port-B address width.
- DATA_W, 7, LUT word width.
- RD_LAT, 1, cycles from addrb change to valid doutb (1..3).

Ports:
- clk  in  1  LUT port-B clock (slow_clk)
- rst  in  1  synchronous active-high reset
- rx_data  in  8  command/data byte from host
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  byte accepted when rx_valid & rx_ready
- tx_data  out  8  readback byte, {1'b0, lut word}
- tx_valid  out  1  tx_data valid, held until accepted
- tx_ready  in  1  host accepts tx byte
- bpm_lut_dinb  out  7  write data, shared by all LUTs
- bpm_lut_addrb  out  15  port-B address, shared
- bpm1_i_lut_web, bpm1_q_lut_web, bpm2_i_lut_web, bpm2_q_lut_web  out  1 each  per-LUT write enable
- bpm1_i_lut_doutb, bpm1_q_lut_doutb, bpm2_i_lut_doutb, bpm2_q_lut_doutb  in  7 each  port-B read data
- clr_err  in  1  clears proto_err
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse on transaction completion
- proto_err  out  1  sticky protocol error

Behaviour:
- Reset values: rx_ready=0, tx_valid=0, tx_data=0, all web=0, addrb=0, dinb=0, busy=0, done=0, proto_err=0, state=IDLE.
- Frame format:
  - CMD byte: bit7 = read(1)/write(0), bits[1:0] = LUT select (0 bpm1_i, 1 bpm1_q, 2 bpm2_i, 3 bpm2_q), bits[6:2] must be 0.
  - ADDR_HI (bits[6:0] = addr[14:8]; bit7 ignored), then ADDR_LO.
  - LEN_HI, LEN_LO: word count minus 1, 16 bits; bit15 ignored, so 1..32768 words.
  - Write frames only: LEN+1 data bytes, bits[6:0] used, bit7 ignored.
- States: IDLE, ADDR_HI, ADDR_LO, LEN_HI, LEN_LO, WR_DATA, [WR_CSUM], RD_ADDR, RD_WAIT, RD_SEND, DONE.
- rx_ready is 1 in IDLE, ADDR_*, LEN_*, WR_DATA and WR_CSUM. It is 0 in all read states and in DONE.
- IDLE: an invalid CMD (bits[6:2]!=0) sets proto_err; the byte is dropped and the state stays IDLE.
- Write path:
  - Each accepted data byte produces, on the next cycle, addrb=current address, dinb=byte[6:0] and a single-cycle web on the selected LUT only.
  - The address increments after each write and wraps from 0x7FFF to 0x0000.
  - The remaining count decrements per write. After the final word, go to DONE (or WR_CSUM when the option is enabled).
- Read path:
  - RD_ADDR drives addrb.
  - RD_WAIT waits RD_LAT cycles, then captures the selected doutb into tx_data and asserts tx_valid.
  - RD_SEND holds tx_data and tx_valid stable until tx_ready. On acceptance: address+1 (with wrap), count-1, then RD_ADDR or DONE.
  - Peak throughput is one word per RD_LAT+2 cycles.
- DONE: done=1 for one cycle, then IDLE.
- web is never asserted outside WR_DATA; the 4 web outputs are mutually exclusive.
- clr_err clears proto_err. If clr_err and a new error occur in the same cycle, the error wins (proto_err=1).
- rst at any point aborts the transaction: outputs go to reset values the next cycle and no web pulse follows. A partially written LUT is left as written.

Optional Feature:
- Macro: LUT_LOADER_CHECKSUM_EN.
- Enabled:
  - Write frames carry one trailing byte equal to the 8-bit modulo sum of CMD, both ADDR, both LEN and all data bytes.
  - WR_CSUM receives this byte. A mismatch sets proto_err.
  - done still pulses; previously written words are not rolled back.
- Disabled: there is no trailer byte and WR_CSUM does not exist.

Decomposition:
- Shared package lut_loader_pkg: state enum, LUT-select encodings (LUT_BPM1_I=0..LUT_BPM2_Q=3), CMD bit positions, CMD reserved-bits mask.
- One natural sub-module, lut_loader_rd_pipe: RD_LAT-deep delay of the read request plus doutb mux/capture.

Test Plan:
- Write bpm2_q, addr 0x0010, LEN=2, data 0x11,0x22,0x33 -> exactly three bpm2_q_lut_web pulses at addr 0x10,0x11,0x12 with dinb 0x11,0x22,0x33; other webs stay 0; one done pulse.
- Write bpm1_i at 0x7FFF, LEN=1 -> writes at 0x7FFF then 0x0000 (wrap).
- Read bpm1_q addr 0x0100, LEN=3, doutb model returns addr[6:0], tx_ready toggled 1/0 every cycle -> tx bytes 0x00,0x01,0x02,0x03; tx_data stable while tx_valid=1 and tx_ready=0.
- CMD 0x04 -> proto_err=1, busy stays 0; then clr_err -> proto_err=0; a valid frame afterwards completes normally.
- rst asserted mid-write after 1 of 4 data bytes -> exactly one web pulse total, busy=0 and rx_ready=0 the cycle after rst; next frame decodes from CMD.
- With LUT_LOADER_CHECKSUM_EN: correct trailer -> proto_err=0; trailer off by 1 -> proto_err=1, all data words still written, done pulses.
